// File: rtl/reg_board_pkg.sv
// Shared definitions for the register-board sequencer.
// Holds the capture FSM state encoding, the display source codes, the button
// index map and the bit positions of the config fields inside the switch word.
package reg_board_pkg;

  // Capture FSM states; the low two bits of the first four double as the LED step code
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GOT_CFG  = 3'd1,
    ST_GOT_DATA = 3'd2,
    ST_READY    = 3'd3,
    ST_COMMIT   = 3'd4
  } state_t;

  // Display source selection codes
  localparam logic [2:0] DISP_A    = 3'd0;
  localparam logic [2:0] DISP_B    = 3'd1;
  localparam logic [2:0] DISP_C    = 3'd2;
  localparam logic [2:0] DISP_R15  = 3'd3;
  localparam logic [2:0] DISP_PC   = 3'd4;
  localparam logic [2:0] DISP_ZERO = 3'd5;

  // Button slots in the debouncer bank
  localparam int BTN_LOAD = 0;
  localparam int BTN_EXEC = 1;
  localparam int BTN_DISP = 2;
  localparam int NUM_BTN  = 3;

  // Config word field positions (LSB of each field)
  localparam int SW_ADDR_A_LSB = 28;
  localparam int SW_ADDR_B_LSB = 23;
  localparam int SW_ADDR_C_LSB = 19;
  localparam int SW_M_LSB      = 12;
  localparam int SW_M_W        = 5;
  localparam int SW_W_ADDR_LSB = 6;
  localparam int SW_WR_REG_BIT = 1;
  localparam int SW_WR_PC_BIT  = 0;

  // Display index advances 0..5 and wraps back to 0
  function automatic logic [2:0] disp_next(input logic [2:0] cur);
    return (cur == DISP_ZERO) ? DISP_A : cur + 3'd1;
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button conditioner: 2-FF synchronizer, debounce counter, rising-edge pulse.
// Ports:
//   clk     - clock
//   clr     - asynchronous active-high reset
//   i_btn   - raw, asynchronous button level
//   o_pulse - one-cycle pulse when a debounced press is accepted
module btn_pulse
  import reg_board_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic clr,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_stable;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // The counter only runs while the synchronized level disagrees with the
  // accepted level; any return to agreement (a glitch) restarts it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_sync0  <= 1'b0;
      r_sync1  <= 1'b0;
      r_stable <= 1'b0;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
      r_pulse <= 1'b0;
      if (r_sync1 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync1;
        r_cnt    <= '0;
        r_pulse  <= r_sync1;  // only an accepted press emits a pulse, not a release
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/reg_board_seq.sv
// Button-driven sequencer for a 3-read/1-write register file with PC.
// Three LOAD presses capture a config word, write data and a new PC from the
// switches; an EXEC press in READY issues one-cycle write strobes. A DISPLAY
// press steps the 7-seg source through A, B, C, R15, PC and zero.
// Ports:
//   clk, clr                      - clock, asynchronous active-high reset
//   sw                            - 32-bit switch word
//   btn_load/btn_exec/btn_disp    - raw buttons
//   R_Data_A/B/C, pc_in           - register file read data and current PC
//   R_Addr_A/B/C, M, W_Addr       - captured addresses and mode
//   W_Data, PC_New                - captured write data and PC value
//   Write_Reg, Write_PC           - one-cycle commit strobes
//   load_step                     - LED step code (0..3)
//   disp_sel, disp_data           - display source index and selected word
module reg_board_seq
  import reg_board_pkg::*;
#(
  parameter int          SIZE      = 32,
  parameter int          ADDR      = 4,
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     sw,
  input  logic            btn_load,
  input  logic            btn_exec,
  input  logic            btn_disp,
  input  logic [SIZE-1:0] R_Data_A,
  input  logic [SIZE-1:0] R_Data_B,
  input  logic [SIZE-1:0] R_Data_C,
  input  logic [SIZE-1:0] pc_in,
  output logic [ADDR-1:0] R_Addr_A,
  output logic [ADDR-1:0] R_Addr_B,
  output logic [ADDR-1:0] R_Addr_C,
  output logic [4:0]      M,
  output logic [ADDR-1:0] W_Addr,
  output logic [SIZE-1:0] W_Data,
  output logic [SIZE-1:0] PC_New,
  output logic            Write_Reg,
  output logic            Write_PC,
  output logic [1:0]      load_step,
  output logic [2:0]      disp_sel,
  output logic [SIZE-1:0] disp_data
);

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_btn_pulse;
  logic               w_load;
  logic               w_exec;
  logic               w_disp;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR-1:0] r_addr_a;
  logic [ADDR-1:0] r_addr_b;
  logic [ADDR-1:0] r_addr_c;
  logic [4:0]      r_mode;
  logic [ADDR-1:0] r_w_addr;
  logic [SIZE-1:0] r_w_data;
  logic [SIZE-1:0] r_pc_new;
  logic            r_wr_reg;
  logic            r_wr_pc;
  logic [2:0]      r_disp_sel;

  assign w_btn_raw = {btn_disp, btn_exec, btn_load};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_pulse #(
      .DB_CYCLES(DB_CYCLES)
    ) u_btn (
      .clk    (clk),
      .clr    (clr),
      .i_btn  (w_btn_raw[gi]),
      .o_pulse(w_btn_pulse[gi])
    );
  end

  // Load has priority: a coincident exec pulse is discarded.
  assign w_load = w_btn_pulse[BTN_LOAD];
  assign w_exec = w_btn_pulse[BTN_EXEC] & ~w_btn_pulse[BTN_LOAD];
  assign w_disp = w_btn_pulse[BTN_DISP];

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; COMMIT always lasts one cycle and ignores buttons
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_load) w_state_next = ST_GOT_CFG;
      ST_GOT_CFG:  if (w_load) w_state_next = ST_GOT_DATA;
      ST_GOT_DATA: if (w_load) w_state_next = ST_READY;
      ST_READY: begin
        if (w_load)      w_state_next = ST_GOT_CFG;
        else if (w_exec) w_state_next = ST_COMMIT;
      end
      ST_COMMIT:   w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Output logic; strobes are derived from state so reset removes them at once
  always_comb begin
    load_step = 2'd0;
    Write_Reg = 1'b0;
    Write_PC  = 1'b0;
    case (r_state)
      ST_IDLE:     load_step = 2'd0;
      ST_GOT_CFG:  load_step = 2'd1;
      ST_GOT_DATA: load_step = 2'd2;
      ST_READY:    load_step = 2'd3;
      ST_COMMIT: begin
        load_step = 2'd3;
        Write_Reg = r_wr_reg;
        Write_PC  = r_wr_pc;
      end
      default:     load_step = 2'd0;
    endcase
  end

  // Captured fields; READY behaves like IDLE so a fourth load restarts the sequence
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_c <= '0;
      r_mode   <= '0;
      r_w_addr <= '0;
      r_w_data <= '0;
      r_pc_new <= '0;
      r_wr_reg <= 1'b0;
      r_wr_pc  <= 1'b0;
    end else if (w_load) begin
      case (r_state)
        ST_IDLE, ST_READY: begin
          r_addr_a <= sw[SW_ADDR_A_LSB +: ADDR];
          r_addr_b <= sw[SW_ADDR_B_LSB +: ADDR];
          r_addr_c <= sw[SW_ADDR_C_LSB +: ADDR];
          r_mode   <= sw[SW_M_LSB +: SW_M_W];
          r_w_addr <= sw[SW_W_ADDR_LSB +: ADDR];
          r_wr_reg <= sw[SW_WR_REG_BIT];
          r_wr_pc  <= sw[SW_WR_PC_BIT];
        end
        ST_GOT_CFG:  r_w_data <= SIZE'(sw);
        ST_GOT_DATA: r_pc_new <= SIZE'(sw);
        default: ;
      endcase
    end
  end

  // Display source counter, independent of the capture FSM
  always_ff @(posedge clk or posedge clr) begin
    if (clr)         r_disp_sel <= DISP_A;
    else if (w_disp) r_disp_sel <= disp_next(r_disp_sel);
  end

  always_comb begin
    disp_data = '0;
    case (r_disp_sel)
      DISP_A:    disp_data = R_Data_A;
      DISP_B:    disp_data = R_Data_B;
      DISP_C:    disp_data = R_Data_C;
      DISP_R15:  disp_data = R_Data_C;  // port C is steered to R15 below
      DISP_PC:   disp_data = pc_in;
      DISP_ZERO: disp_data = '0;
      default:   disp_data = '0;
    endcase
  end

  assign R_Addr_A = r_addr_a;
  assign R_Addr_B = r_addr_b;
  assign R_Addr_C = (r_disp_sel == DISP_R15) ? {ADDR{1'b1}} : r_addr_c;
  assign M        = r_mode;
  assign W_Addr   = r_w_addr;
  assign W_Data   = r_w_data;
  assign PC_New   = r_pc_new;
  assign disp_sel = r_disp_sel;

endmodule

// File: tb/tb_reg_board_seq.sv
// Self-checking bench for reg_board_seq (DB_CYCLES=4). Stimulus updates a
// behavioural model and queues the expected observable events; an independent
// monitor pops and compares whenever the DUT shows a strobe, a step change or
// a display change.
module tb_reg_board_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] sw;
  logic        btn_load, btn_exec, btn_disp;
  logic [31:0] R_Data_A, R_Data_B, R_Data_C, pc_in;
  logic [3:0]  R_Addr_A, R_Addr_B, R_Addr_C, W_Addr;
  logic [4:0]  M;
  logic [31:0] W_Data, PC_New, disp_data;
  logic        Write_Reg, Write_PC;
  logic [1:0]  load_step;
  logic [2:0]  disp_sel;

  reg_board_seq #(.SIZE(32), .ADDR(4), .DB_CYCLES(4)) dut (
    .clk(clk), .clr(clr), .sw(sw),
    .btn_load(btn_load), .btn_exec(btn_exec), .btn_disp(btn_disp),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B), .R_Data_C(R_Data_C), .pc_in(pc_in),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .R_Addr_C(R_Addr_C), .M(M),
    .W_Addr(W_Addr), .W_Data(W_Data), .PC_New(PC_New),
    .Write_Reg(Write_Reg), .Write_PC(Write_PC),
    .load_step(load_step), .disp_sel(disp_sel), .disp_data(disp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  step;
    logic [3:0]  a, b, c, wa;
    logic [4:0]  m;
    logic [31:0] wd, pc;
  } step_exp_t;

  typedef struct {
    logic        wr, wp;
    logic [3:0]  wa;
    logic [31:0] wd, pc;
  } commit_exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
    logic [3:0]  c;
  } disp_exp_t;

  step_exp_t   q_step[$];
  commit_exp_t q_commit[$];
  disp_exp_t   q_disp[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_step;
  int          m_disp;
  logic [3:0]  m_a, m_b, m_c, m_wa;
  logic [4:0]  m_m;
  logic        m_wr, m_wp;
  logic [31:0] m_wd, m_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [3:0] exp_addr_c();
    return (m_disp == 3) ? 4'hF : m_c;
  endfunction

  function automatic logic [31:0] exp_disp_data(input int s);
    case (s)
      0: return R_Data_A;
      1: return R_Data_B;
      2: return R_Data_C;
      3: return R_Data_C;
      4: return pc_in;
      default: return 32'h0;
    endcase
  endfunction

  task automatic push_step();
    step_exp_t e;
    e.step = 2'(m_step); e.a = m_a; e.b = m_b; e.c = exp_addr_c(); e.wa = m_wa;
    e.m = m_m; e.wd = m_wd; e.pc = m_pc;
    q_step.push_back(e);
  endtask

  task automatic push_disp();
    disp_exp_t e;
    e.sel = 3'(m_disp); e.data = exp_disp_data(m_disp); e.c = exp_addr_c();
    q_disp.push_back(e);
  endtask

  task automatic model_reset();
    m_step = 0; m_disp = 0;
    m_a = 0; m_b = 0; m_c = 0; m_wa = 0; m_m = 0; m_wr = 0; m_wp = 0; m_wd = 0; m_pc = 0;
  endtask

  task automatic model_load(input logic [31:0] v);
    if (m_step == 0 || m_step == 3) begin
      m_a = v[31:28]; m_b = v[26:23]; m_c = v[22:19]; m_m = v[16:12];
      m_wa = v[9:6]; m_wr = v[1]; m_wp = v[0];
      m_step = 1;
    end else if (m_step == 1) begin
      m_wd = v; m_step = 2;
    end else begin
      m_pc = v; m_step = 3;
    end
    push_step();
  endtask

  task automatic model_exec();
    commit_exp_t c;
    if (m_step == 3) begin
      if (m_wr || m_wp) begin
        c.wr = m_wr; c.wp = m_wp; c.wa = m_wa; c.wd = m_wd; c.pc = m_pc;
        q_commit.push_back(c);
      end
      m_step = 0;
      push_step();
    end
  endtask

  task automatic model_disp();
    m_disp = (m_disp + 1) % 6;
    push_disp();
  endtask

  // Hold the chosen buttons long enough to be accepted, then release and settle
  task automatic press(input logic l, input logic e, input logic d);
    @(posedge clk); #1;
    btn_load = l; btn_exec = e; btn_disp = d;
    repeat (12) @(posedge clk);
    #1;
    btn_load = 0; btn_exec = 0; btn_disp = 0;
    repeat (12) @(posedge clk);
  endtask

  task automatic do_load(input logic [31:0] v);
    @(posedge clk); #1; sw = v;
    model_load(v);
    press(1, 0, 0);
  endtask

  task automatic do_exec();
    model_exec();
    press(0, 1, 0);
  endtask

  task automatic do_load_exec(input logic [31:0] v);
    @(posedge clk); #1; sw = v;
    model_load(v);
    press(1, 1, 0);
  endtask

  task automatic do_disp();
    model_disp();
    press(0, 0, 1);
  endtask

  // Monitor: compares every observable event against the queued expectations
  logic [1:0] mon_prev_step;
  logic [2:0] mon_prev_disp;
  logic       mon_prev_strobe;
  initial begin
    wait (clr == 1'b0);
    @(negedge clk);
    mon_prev_step   = load_step;
    mon_prev_disp   = disp_sel;
    mon_prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_prev_strobe) chk("strobe_width", {62'd0, Write_Reg, Write_PC}, 64'd0);
      if (Write_Reg || Write_PC) begin
        if (q_commit.size() == 0) begin
          chk("unexpected_strobe", {62'd0, Write_Reg, Write_PC}, 64'd0);
        end else begin
          commit_exp_t c;
          c = q_commit.pop_front();
          $display("commit: Write_Reg=%0b Write_PC=%0b W_Addr=%0h W_Data=%08h PC_New=%08h",
                   Write_Reg, Write_PC, W_Addr, W_Data, PC_New);
          chk("commit_Write_Reg", Write_Reg, c.wr);
          chk("commit_Write_PC",  Write_PC,  c.wp);
          chk("commit_W_Addr",    W_Addr,    c.wa);
          chk("commit_W_Data",    W_Data,    c.wd);
          chk("commit_PC_New",    PC_New,    c.pc);
        end
      end
      if (load_step != mon_prev_step) begin
        if (q_step.size() == 0) begin
          chk("unexpected_step_change", load_step, mon_prev_step);
        end else begin
          step_exp_t e;
          e = q_step.pop_front();
          $display("step: load_step=%0d A=%0h B=%0h C=%0h M=%0h W_Addr=%0h W_Data=%08h PC_New=%08h",
                   load_step, R_Addr_A, R_Addr_B, R_Addr_C, M, W_Addr, W_Data, PC_New);
          chk("step_load_step", load_step, e.step);
          chk("step_R_Addr_A",  R_Addr_A,  e.a);
          chk("step_R_Addr_B",  R_Addr_B,  e.b);
          chk("step_R_Addr_C",  R_Addr_C,  e.c);
          chk("step_M",         M,         e.m);
          chk("step_W_Addr",    W_Addr,    e.wa);
          chk("step_W_Data",    W_Data,    e.wd);
          chk("step_PC_New",    PC_New,    e.pc);
        end
      end
      if (disp_sel != mon_prev_disp) begin
        if (q_disp.size() == 0) begin
          chk("unexpected_disp_change", disp_sel, mon_prev_disp);
        end else begin
          disp_exp_t d;
          d = q_disp.pop_front();
          $display("disp: disp_sel=%0d disp_data=%08h R_Addr_C=%0h", disp_sel, disp_data, R_Addr_C);
          chk("disp_sel",       disp_sel,  d.sel);
          chk("disp_data",      disp_data, d.data);
          chk("disp_R_Addr_C",  R_Addr_C,  d.c);
        end
      end
      mon_prev_step   = load_step;
      mon_prev_disp   = disp_sel;
      mon_prev_strobe = Write_Reg | Write_PC;
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_R_Addr_A"},  R_Addr_A,  0);
    chk({tag, "_R_Addr_B"},  R_Addr_B,  0);
    chk({tag, "_R_Addr_C"},  R_Addr_C,  0);
    chk({tag, "_M"},         M,         0);
    chk({tag, "_W_Addr"},    W_Addr,    0);
    chk({tag, "_W_Data"},    W_Data,    0);
    chk({tag, "_PC_New"},    PC_New,    0);
    chk({tag, "_Write_Reg"}, Write_Reg, 0);
    chk({tag, "_Write_PC"},  Write_PC,  0);
    chk({tag, "_load_step"}, load_step, 0);
    chk({tag, "_disp_sel"},  disp_sel,  0);
  endtask

  initial begin
    clr = 1'b1; sw = 0; btn_load = 0; btn_exec = 0; btn_disp = 0;
    R_Data_A = $urandom; R_Data_B = $urandom; R_Data_C = $urandom; pc_in = $urandom;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    clr = 1'b0;
    repeat (3) @(posedge clk);

    // Full write sequence
    do_load(32'h1234_32C2);
    do_load(32'hDEAD_BEEF);
    do_load(32'h0000_0040);
    do_exec();

    // Exec while GOT_DATA is ignored
    do_load($urandom);
    do_load($urandom);
    do_exec();
    #1 chk("exec_in_got_data_step", load_step, 2'd2);
    do_load($urandom);

    // Load and exec together while READY: load wins
    do_load_exec($urandom);
    #1 chk("load_exec_together_step", load_step, 2'd1);

    // Bouncing load button gives exactly one capture
    @(posedge clk); #1;
    sw = $urandom;
    model_load(sw);
    for (int i = 0; i < 10; i++) begin
      btn_load = ~btn_load;
      repeat (2) @(posedge clk);
      #1;
    end
    btn_load = 1;
    repeat (12) @(posedge clk);
    #1 btn_load = 0;
    repeat (12) @(posedge clk);
    #1 chk("bounce_step", load_step, 2'd2);

    // Seven display presses walk 1..5, 0, 1
    for (int i = 0; i < 7; i++) do_disp();

    // Reset in mid-sequence with a partial load and nonzero display
    do_load($urandom);
    do_load($urandom);
    @(posedge clk); #3;
    if (m_step != 0) begin model_reset(); m_disp = 1; m_step = 0; push_step(); end
    if (m_disp != 0) begin m_disp = 0; push_disp(); end
    model_reset();
    clr = 1'b1;
    #1;
    check_all_zero("midrun_reset");
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    repeat (3) @(posedge clk);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4)      do_load($urandom);
      else if (op <= 6) do_exec();
      else if (op == 7) do_load_exec($urandom);
      else              do_disp();
    end

    repeat (20) @(posedge clk);
    #1;
    chk("leftover_step_events",   q_step.size(),   0);
    chk("leftover_commit_events", q_commit.size(), 0);
    chk("leftover_disp_events",   q_disp.size(),   0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
